// File: rtl/fetch_icache.sv
// Direct-mapped I-cache; build with ICACHE_STATS_EN for hit/miss counters.
// Latency: hits return combinationally; a miss holds stall for 1 + beat waits + 1 cycles.
// Backpressure: refill beats hold mem_req/mem_addr stable until mem_ready.
module fetch_icache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    output logic        stall,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int OB    = 2 + OFF_W;
    localparam int TAG_W = 32 - OB - IDX_W;
    localparam logic [31:0]      NOP       = 32'h0000_0013;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             cancel_q, cancel_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tags_q [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             lookup_hit;
    logic             beat_acc;
    logic             fill_last;
    logic             hit_fire;
    logic             miss_fire;
    logic             unused_pc_bits;

    assign req_off        = req_pc[OB-1:2];
    assign req_idx        = req_pc[OB+IDX_W-1:OB];
    assign req_tag        = req_pc[31:OB+IDX_W];
    assign unused_pc_bits = ^req_pc[1:0];

    assign lookup_hit = req_valid && valid_q[req_idx] && (tags_q[req_idx] == req_tag);
    assign beat_acc   = (state_q == REFILL) && mem_ready;
    assign fill_last  = beat_acc && (beat_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        beat_d     = beat_q;
        cancel_d   = cancel_q;
        resp_valid = 1'b0;
        resp_instr = NOP;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        hit_fire   = 1'b0;
        miss_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (lookup_hit) begin
                        resp_valid = 1'b1;
                        resp_instr = data_q[req_idx][req_off];
                        hit_fire   = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        miss_fire  = 1'b1;
                        fill_tag_d = req_tag;
                        fill_idx_d = req_idx;
                        beat_d     = '0;
                        cancel_d   = 1'b0;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {fill_tag_q, fill_idx_q, beat_q, 2'b00};
                // An invalidate anywhere in the refill poisons the line being filled.
                if (invalidate) cancel_d = 1'b1;
                if (mem_ready) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs go quiet the moment reset is asserted, even with req_valid held.
        if (!reset) begin
            resp_valid = 1'b0;
            resp_instr = NOP;
            stall      = 1'b0;
            mem_req    = 1'b0;
            mem_addr   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            beat_q     <= '0;
            cancel_q   <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            beat_q     <= beat_d;
            cancel_q   <= cancel_d;
            if (invalidate)
                valid_q <= '0;
            else if (fill_last && !cancel_q)
                valid_q[fill_idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_acc) data_q[fill_idx_q][beat_q] <= mem_rdata;
        if (fill_last) tags_q[fill_idx_q] <= fill_tag_q;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_fire)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_fire) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_fire ^ miss_fire;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_fetch_icache.sv
// Randomized bench for fetch_icache against a line-level behavioural cache model.
module tb_fetch_icache;
    localparam int LINES = 16;
    localparam int WPL   = 4;
    localparam logic [31:0] LINE_MASK = ~32'(4 * WPL - 1);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        stall;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    fetch_icache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .stall      (stall),
        .invalidate (invalidate),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: which line holds which tag, plus event counts.
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    int unsigned m_hits;
    int unsigned m_miss;

    function automatic int unsigned line_of(input logic [31:0] pc);
        return (pc / (4 * WPL)) % LINES;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * WPL * LINES);
    endfunction

    function automatic logic [31:0] stat(input int unsigned v);
`ifdef ICACHE_STATS_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_hits = 0;
        m_miss = 0;
    endtask

    // Memory: word at address A holds A+1; mem_wait idle cycles before each beat.
    int          mem_wait = 0;
    logic [31:0] beats[$];

    initial begin
        int          cnt;
        logic [31:0] hold;
        cnt       = 0;
        hold      = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (cnt == 0) hold = mem_addr;
                else chk("addr_stable", mem_addr, hold);
                if (cnt >= mem_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr + 32'd1;
                    beats.push_back(mem_addr);
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // One fetch held until served; inv_at>0 pulses invalidate that many cycles into the miss.
    task automatic fetch(input logic [31:0] pc, input int w, input int inv_at);
        bit          exp_hit;
        int          cnt;
        int          nref;
        int unsigned ln;
        logic [31:0] base;
        ln       = line_of(pc);
        base     = pc & LINE_MASK;
        mem_wait = w;
        beats.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = pc;
        #1;
        exp_hit = m_valid[ln] && (m_tag[ln] == tag_of(pc));
        chk("hit_count", hit_count, stat(m_hits));
        chk("miss_count", miss_count, stat(m_miss));
        chk("first_resp_valid", 32'(resp_valid), 32'(exp_hit));
        chk("first_stall", 32'(stall), 32'(!exp_hit));
        cnt = 0;
        while (stall === 1'b1 && cnt < 400) begin
            invalidate = (cnt == inv_at);
            cnt++;
            @(negedge clk);
            #1;
        end
        invalidate = 1'b0;
        nref = exp_hit ? 0 : ((inv_at > 0) ? 2 : 1);
        chk("stall_cycles", 32'(cnt), 32'(nref * (2 + WPL * (w + 1))));
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_instr", resp_instr, (pc & ~32'd3) + 32'd1);
        if (!exp_hit) begin
            chk("beat_count", 32'(beats.size()), 32'(nref * WPL));
            for (int i = 0; i < beats.size(); i++)
                chk("beat_addr", beats[i], base + 32'(4 * (i % WPL)));
        end
        if (!exp_hit && inv_at > 0) model_clear();
        m_valid[ln] = 1'b1;
        m_tag[ln]   = tag_of(pc);
        m_miss     += nref;
        m_hits     += 1;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_pc     = '0;
        invalidate = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_instr", resp_instr, NOP);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        fetch(32'h100, 0, -1);
        fetch(32'h104, 0, -1);
        fetch(32'h108, 0, -1);
        fetch(32'h10C, 0, -1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("line_hits_total", hit_count, stat(4));

        fetch(32'h200, 0, -1);
        fetch(32'h100, 0, -1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("conflict_misses", miss_count, stat(3));

        fetch(32'h340, 3, -1);
        fetch(32'h480, 0, 3);

        // Invalidate coincident with a hit: hit still served, clear seen next cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_pc     = 32'h480;
        invalidate = 1'b1;
        #1;
        chk("inv_hit_valid", 32'(resp_valid), 32'd1);
        chk("inv_hit_instr", resp_instr, 32'h481);
        chk("inv_hit_stall", 32'(stall), 32'd0);
        @(negedge clk);
        invalidate = 1'b0;
        req_valid  = 1'b0;
        #1;
        chk("idle_no_stall", 32'(stall), 32'd0);
        chk("idle_resp_instr", resp_instr, NOP);
        m_hits++;
        model_clear();
        fetch(32'h480, 0, -1);

        // Reset dropped while beat 1 is outstanding.
        mem_wait = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = 32'h540;
        #1;
        chk("rst_mid_miss_stall", 32'(stall), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mid_mem_req_before", 32'(mem_req), 32'd1);
        chk("rst_mid_beat1_addr", mem_addr, 32'h544);
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_hit_count", hit_count, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        model_reset();
        fetch(32'h540, 0, -1);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge clk);
                req_valid  = 1'b0;
                invalidate = 1'b1;
                @(negedge clk);
                invalidate = 1'b0;
                model_clear();
            end else if (r == 1) begin
                @(negedge clk);
                req_valid = 1'b0;
            end else begin
                logic [31:0] pc;
                pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
                   | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                fetch(pc, $urandom_range(0, 2),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : -1);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("final_hit_count", hit_count, stat(m_hits));
        chk("final_miss_count", miss_count, stat(m_miss));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
